// File: rtl/cmos_sensor_acquisition.sv
// cmos_sensor_acquisition
//   Receive side of a CMOS sensor parallel interface. The frame_valid/line_valid/data
//   pins are registered once, frame boundaries are tracked by a small FSM, and pixels
//   are tagged with start-of-frame / end-of-line. Tagged pixels go into a FIFO that feeds
//   a valid/ready stream. The sensor cannot be stalled: a full FIFO drops pixels and
//   sets the sticky overflow flag.
//
// Optional build macro: CMOS_ACQ_STATS_EN
//   defined     : per-line pixel and per-frame line counters drive last_width,
//                 last_height and frame_count (updated in the frame_done cycle).
//   not defined : counters not built; the three stats outputs read 0.
//
// Ports
//   clk, reset                      system clock, synchronous active-high reset
//   enable                          acquire frames; drop stops at a frame boundary
//   clear_flags                     one-cycle pulse clearing overflow / protocol_error
//   cmos_frame_valid/line_valid     sensor FV / LV
//   cmos_data                       sensor pixel, meaningful when FV & LV
//   out_data/out_sof/out_eol        stream payload
//   out_valid/out_ready             stream handshake
//   frame_done                      one-cycle pulse when a frame has been written
//   busy                            FSM is inside a frame
//   overflow/protocol_error         sticky error flags
//   last_width/last_height          geometry of the last complete frame
//   frame_count                     completed frames, wrapping

module cmos_sensor_acquisition #(
    parameter int DATA_WIDTH = 12,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  clear_flags,
    input  logic                  cmos_frame_valid,
    input  logic                  cmos_line_valid,
    input  logic [DATA_WIDTH-1:0] cmos_data,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_sof,
    output logic                  out_eol,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  frame_done,
    output logic                  busy,
    output logic                  overflow,
    output logic                  protocol_error,
    output logic [15:0]           last_width,
    output logic [15:0]           last_height,
    output logic [15:0]           frame_count
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [AW-1:0] PTR_ONE = AW'(1);
    localparam logic [AW:0]   CNT_ONE = (AW + 1)'(1);
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        SYNC,
        WAIT_SOF,
        IN_FRAME
    } state_t;

    state_t state, state_next;

    // ---------------- input sync stage ----------------
    logic                  fv_q, lv_q;
    logic [DATA_WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            fv_q   <= 1'b0;
            lv_q   <= 1'b0;
            data_q <= '0;
        end else begin
            fv_q   <= cmos_frame_valid;
            lv_q   <= cmos_line_valid;
            data_q <= cmos_data;
        end
    end

    logic pixel_in;
    assign pixel_in = fv_q & lv_q;

    // ---------------- frame FSM ----------------
    logic frame_end;
    logic enter_frame;

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    always_comb begin
        state_next  = state;
        frame_end   = 1'b0;
        enter_frame = 1'b0;
        case (state)
            IDLE:     if (enable) state_next = SYNC;
            SYNC: begin
                if (!enable)   state_next = IDLE;
                else if (!fv_q) state_next = WAIT_SOF;
            end
            WAIT_SOF: begin
                if (!enable) state_next = IDLE;
                else if (fv_q) begin
                    state_next  = IN_FRAME;
                    enter_frame = 1'b1;
                end
            end
            IN_FRAME: begin
                if (!fv_q) begin
                    frame_end  = 1'b1;
                    state_next = enable ? WAIT_SOF : IDLE;
                end
            end
            default:  state_next = IDLE;
        endcase
    end

    assign busy = (state == IN_FRAME);

    // ---------------- one-pixel lookahead hold ----------------
    // A pixel is held for one sample so its eol can be decided from the LV of the
    // sample that follows it; an FV fall therefore always flushes it with eol set.
    logic                  hold_valid, hold_sof, sof_pending;
    logic [DATA_WIDTH-1:0] hold_data;
    logic                  push, push_eol;

    assign push     = hold_valid;
    assign push_eol = ~pixel_in;

    always_ff @(posedge clk) begin
        if (reset) begin
            hold_valid  <= 1'b0;
            hold_sof    <= 1'b0;
            hold_data   <= '0;
            sof_pending <= 1'b0;
        end else begin
            hold_valid <= busy & pixel_in;
            if (busy && pixel_in) begin
                hold_data   <= data_q;
                hold_sof    <= sof_pending;
                sof_pending <= 1'b0;
            end
            if (enter_frame) sof_pending <= 1'b1;
        end
    end

    // ---------------- pixel FIFO ----------------
    logic [DATA_WIDTH+1:0] mem [FIFO_DEPTH];
    logic [AW-1:0]         wr_ptr, rd_ptr;
    logic [AW:0]           count;
    logic                  full, pop, wr_en;
    logic [DATA_WIDTH+1:0] rd_word;

    assign full      = (count == CNT_FULL);
    assign out_valid = (count != '0);
    assign pop       = out_valid & out_ready;
    assign wr_en     = push & (~full | pop);

    always_ff @(posedge clk) begin
        if (!reset && wr_en) mem[wr_ptr] <= {hold_sof, push_eol, hold_data};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)   rd_ptr <= rd_ptr + PTR_ONE;
            case ({wr_en, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Payload is forced to zero while empty so reset leaves every output at 0.
    assign rd_word  = mem[rd_ptr];
    assign out_data = out_valid ? rd_word[DATA_WIDTH-1:0] : '0;
    assign out_eol  = out_valid & rd_word[DATA_WIDTH];
    assign out_sof  = out_valid & rd_word[DATA_WIDTH+1];

    // ---------------- status ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            frame_done     <= 1'b0;
            overflow       <= 1'b0;
            protocol_error <= 1'b0;
        end else begin
            frame_done     <= frame_end;
            // A new event in the same cycle as clear_flags keeps the flag set.
            overflow       <= (push & full & ~pop) | (overflow & ~clear_flags);
            protocol_error <= (lv_q & ~fv_q) | (protocol_error & ~clear_flags);
        end
    end

`ifdef CMOS_ACQ_STATS_EN
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    logic [15:0] pix_cnt, line_cnt, cur_width;
    logic [15:0] width_r, height_r, count_r;
    logic        line_close;

    // Captured pixels are counted, whether or not the FIFO had room for them.
    assign line_close = push & push_eol;

    always_ff @(posedge clk) begin
        if (reset) begin
            pix_cnt   <= '0;
            line_cnt  <= '0;
            cur_width <= '0;
            width_r   <= '0;
            height_r  <= '0;
            count_r   <= '0;
        end else begin
            if (enter_frame) begin
                pix_cnt   <= '0;
                line_cnt  <= '0;
                cur_width <= '0;
            end else if (push) begin
                if (push_eol) begin
                    pix_cnt   <= '0;
                    line_cnt  <= sat_inc(line_cnt);
                    cur_width <= sat_inc(pix_cnt);
                end else begin
                    pix_cnt <= sat_inc(pix_cnt);
                end
            end
            // The final flush lands on the frame_end edge, so fold it in directly.
            if (frame_end) begin
                width_r  <= line_close ? sat_inc(pix_cnt) : cur_width;
                height_r <= line_close ? sat_inc(line_cnt) : line_cnt;
                count_r  <= count_r + 16'd1;
            end
        end
    end

    assign last_width  = width_r;
    assign last_height = height_r;
    assign frame_count = count_r;
`else
    assign last_width  = '0;
    assign last_height = '0;
    assign frame_count = '0;
`endif

endmodule

// File: tb/tb_cmos_sensor_acquisition.sv
// Scoreboard bench for cmos_sensor_acquisition. The driver pushes each pixel it expects
// to see on the stream (data, sof = first pixel of frame, eol = last pixel of line) into
// a queue; an independent monitor pops and compares on every stream transfer.
module tb_cmos_sensor_acquisition;

    localparam int DW    = 12;
    localparam int DEPTH = 16;

    localparam int ACT_NONE   = 0;
    localparam int ACT_EN_ON  = 1;
    localparam int ACT_EN_OFF = 2;
    localparam int ACT_RESET  = 3;

    logic          clk = 1'b0;
    logic          reset, enable, clear_flags;
    logic          fv, lv;
    logic [DW-1:0] din;
    logic [DW-1:0] out_data;
    logic          out_sof, out_eol, out_valid, out_ready;
    logic          frame_done, busy, overflow, protocol_error;
    logic [15:0]   last_width, last_height, frame_count;

    always #5 clk = ~clk;

    cmos_sensor_acquisition #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset), .enable(enable), .clear_flags(clear_flags),
        .cmos_frame_valid(fv), .cmos_line_valid(lv), .cmos_data(din),
        .out_data(out_data), .out_sof(out_sof), .out_eol(out_eol),
        .out_valid(out_valid), .out_ready(out_ready),
        .frame_done(frame_done), .busy(busy), .overflow(overflow),
        .protocol_error(protocol_error), .last_width(last_width),
        .last_height(last_height), .frame_count(frame_count)
    );

    typedef struct packed {
        logic          sof;
        logic          eol;
        logic [DW-1:0] data;
    } pix_t;

    pix_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   ready_mode = 0;   // 0 always ready, 1 never ready, 2 random
    int   fd_cnt = 0;
    int   exp_fc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Ready generator: random mode never holds ready low two cycles running.
    initial begin
        out_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = 1'b0;
                default: out_ready = !out_ready ? 1'b1 : ($urandom_range(0, 2) != 0);
            endcase
        end
    end

    // Monitor: scoreboard pops, frame_done counting, stall stability.
    pix_t        mon_e;
    logic        stall_prev = 1'b0;
    logic [31:0] stall_word;

    always @(negedge clk) begin
        if (!reset) begin
            if (frame_done) fd_cnt++;
            if (stall_prev)
                check("stall_hold", {out_valid, out_sof, out_eol, out_data}, stall_word);
            stall_prev = out_valid & !out_ready;
            stall_word = {out_valid, out_sof, out_eol, out_data};
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_pixel: got 0x%0h expected none",
                             {out_sof, out_eol, out_data});
                end else begin
                    mon_e = exp_q.pop_front();
                    check("pixel", {out_sof, out_eol, out_data}, mon_e);
                end
            end
        end else begin
            stall_prev = 1'b0;
        end
    end

    task automatic cyc(input logic f, input logic l, input logic [DW-1:0] d);
        @(posedge clk); #1;
        fv  = f;
        lv  = l;
        din = d;
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, '0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, out_valid, 0);
        check({tag, "_data"}, {out_sof, out_eol, out_data}, 0);
        check({tag, "_flags"}, {frame_done, busy, overflow, protocol_error}, 0);
        check({tag, "_stats"}, {last_width, last_height}, 0);
        check({tag, "_fcount"}, frame_count, 0);
    endtask

    task automatic check_stats(input int w, input int h);
`ifdef CMOS_ACQ_STATS_EN
        check("last_width", last_width, w);
        check("last_height", last_height, h);
        check("frame_count", frame_count, exp_fc);
`else
        check("last_width_off", last_width, 0);
        check("last_height_off", last_height, 0);
        check("frame_count_off", frame_count, 0);
        if (w < 0 || h < 0) $display("bad geometry");
`endif
    endtask

    // Drives one frame: 3-cycle FV front porch, h lines of w pixels separated by gap
    // idle samples, then FV low for 6 cycles. Up to 'keep' pixels are expected.
    task automatic send_frame(input int w, input int h, input int gap, input bit exp,
                              input int keep, input int act_line, input int act);
        int            kept = 0;
        bit            e = exp;
        pix_t          p;
        logic [DW-1:0] d;
        repeat (3) cyc(1'b1, 1'b0, '0);
        for (int y = 0; y < h; y++) begin
            if (y == act_line) begin
                if (act == ACT_EN_ON) enable = 1'b1;
                else if (act == ACT_EN_OFF) enable = 1'b0;
                else if (act == ACT_RESET) begin
                    reset = 1'b1;
                    cyc(1'b1, 1'b0, '0);
                    reset = 1'b0;
                    exp_q.delete();
                    e = 1'b0;
                    exp_fc = 0;
                    check_reset_outputs("midrst");
                end
            end
            for (int x = 0; x < w; x++) begin
                d = DW'($urandom);
                if (e && kept < keep) begin
                    p.sof  = (x == 0) && (y == 0);
                    p.eol  = (x == w - 1);
                    p.data = d;
                    exp_q.push_back(p);
                    kept++;
                end
                cyc(1'b1, 1'b1, d);
            end
            repeat (gap) cyc(1'b1, 1'b0, '0);
        end
        idle(6);
    endtask

    task automatic drain(input string name);
        int n = 0;
        while ((exp_q.size() != 0 || out_valid) && n < 2000) begin
            @(posedge clk); #1;
            n++;
        end
        check({name, "_drain"}, exp_q.size(), 0);
    endtask

    initial begin
        #3_000_000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        int fd0;
        int w, h, g;
        reset = 1'b1; enable = 1'b0; clear_flags = 1'b0;
        fv = 1'b0; lv = 1'b0; din = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check_reset_outputs("reset");

        // 4x3 frame, gap 2, always ready
        enable = 1'b1;
        idle(4);
        fd0 = fd_cnt;
        send_frame(4, 3, 2, 1'b1, 1000, -1, ACT_NONE);
        exp_fc++;
        drain("basic");
        check("basic_frame_done", fd_cnt - fd0, 1);
        check_stats(4, 3);

        // LV with FV low: protocol error, nothing captured
        fd0 = fd_cnt;
        repeat (3) cyc(1'b0, 1'b1, 12'h5A5);
        idle(3);
        check("perr_set", protocol_error, 1);
        check("perr_no_output", {out_valid, busy}, 0);
        clear_flags = 1'b1;
        cyc(1'b0, 1'b0, '0);
        clear_flags = 1'b0;
        check("perr_cleared", protocol_error, 0);
        cyc(1'b0, 1'b1, '0);
        cyc(1'b0, 1'b0, '0);
        clear_flags = 1'b1;
        cyc(1'b0, 1'b0, '0);
        clear_flags = 1'b0;
        check("perr_event_wins", protocol_error, 1);
        clear_flags = 1'b1;
        cyc(1'b0, 1'b0, '0);
        clear_flags = 1'b0;
        check("perr_cleared2", protocol_error, 0);
        check("perr_frame_done", fd_cnt - fd0, 0);

        // Overflow: stream stalled across a 64x2 frame, first DEPTH pixels survive
        ready_mode = 1;
        fd0 = fd_cnt;
        send_frame(64, 2, 2, 1'b1, DEPTH, -1, ACT_NONE);
        exp_fc++;
        check("ovf_set", overflow, 1);
        check("ovf_valid", out_valid, 1);
        check("ovf_queue", exp_q.size(), DEPTH);
        clear_flags = 1'b1;
        cyc(1'b0, 1'b0, '0);
        clear_flags = 1'b0;
        check("ovf_cleared", overflow, 0);
        ready_mode = 0;
        drain("ovf");
        check("ovf_frame_done", fd_cnt - fd0, 1);
        check_stats(64, 2);

        // Enable raised mid-frame: partial frame dropped, next frame captured
        enable = 1'b0;
        idle(3);
        fd0 = fd_cnt;
        send_frame(4, 3, 2, 1'b0, 0, 1, ACT_EN_ON);
        send_frame(6, 2, 2, 1'b1, 1000, -1, ACT_NONE);
        exp_fc++;
        drain("en_mid");
        check("en_mid_frame_done", fd_cnt - fd0, 1);
        check_stats(6, 2);

        // Enable dropped mid-frame: frame completes, following frame ignored
        fd0 = fd_cnt;
        send_frame(5, 3, 3, 1'b1, 1000, 1, ACT_EN_OFF);
        exp_fc++;
        check("en_off_busy", busy, 0);
        send_frame(5, 2, 3, 1'b0, 0, -1, ACT_NONE);
        drain("en_off");
        check("en_off_frame_done", fd_cnt - fd0, 1);
        check_stats(5, 3);

        // Reset mid-frame, then resync on the next frame
        enable = 1'b1;
        idle(4);
        fd0 = fd_cnt;
        send_frame(6, 4, 3, 1'b1, 1000, 2, ACT_RESET);
        send_frame(3, 2, 2, 1'b1, 1000, -1, ACT_NONE);
        exp_fc++;
        drain("rst_mid");
        check("rst_mid_frame_done", fd_cnt - fd0, 1);
        check_stats(3, 2);

        // Randomized frames with random back-pressure
        ready_mode = 2;
        for (int i = 0; i < 20; i++) begin
            w = $urandom_range(1, 8);
            h = $urandom_range(1, 4);
            g = w + 4 + $urandom_range(0, 3);
            fd0 = fd_cnt;
            send_frame(w, h, g, 1'b1, 1000, -1, ACT_NONE);
            exp_fc++;
            drain("rand");
            check("rand_frame_done", fd_cnt - fd0, 1);
            check_stats(w, h);
        end
        check("rand_no_overflow", overflow, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
